// File: rtl/bcd_conv_sched.sv
// Shared binary-to-BCD engine: a round-robin arbiter feeds one shift-add-3 (double-dabble) converter.
// Latency: out_valid rises WIDTH clock edges after the edge that accepts a request.
// Backpressure: one conversion in flight at a time. req_ready is low outside IDLE, and a result
// is held in DONE until out_ready is seen.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   req_valid/req_ready per-requester handshake; req_ready is a one-hot grant, given only in IDLE
//   req_data            NREQ packed operands; requester i at [i*WIDTH +: WIDTH]
//   out_valid/out_ready result handshake
//   out_bcd, out_id     packed BCD result (digit 0 in [3:0]) and the index of its owner
//   busy                high while a conversion is in progress or waiting to be taken
//   conv_count          completed conversions, modulo 256
module bcd_conv_sched #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int NREQ   = 2,
  localparam int IDW   = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [IDW-1:0]        out_id,
  output logic                  busy,
  output logic [7:0]            conv_count
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] opnd_q;
  logic [BW-1:0]    bcd_q;
  logic [BW-1:0]    bcd_adj;
  logic [CW-1:0]    bit_cnt_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   id_q;
  logic [7:0]       conv_cnt_q;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic             grant_any;
  logic             accept;
  logic             shift_en;
  logic             out_hs;

  // Unpack the flat operand bus so the winner can be selected by index.
  logic [WIDTH-1:0] req_opnd [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_opnd[i] = req_data[i*WIDTH +: WIDTH];
  end

  // Round-robin pick: scan from ptr_q upward, wrapping modulo NREQ.
  // The first valid requester found wins.
  always_comb begin : rr_pick
    int             cand;
    logic [IDW-1:0] sel;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    sel       = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      sel = IDW'(cand);
      if (!grant_any && req_valid[sel]) begin
        grant_any = 1'b1;
        grant_idx = sel;
      end
    end
    grant[grant_idx] = grant_any;
  end

  // Add-3 correction: every digit that is 5 or more gets +3 before the shift.
  // There is no carry between digits, because the shift that follows does the doubling.
  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) begin
        bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-state strobes
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    shift_en  = 1'b0;
    out_hs    = 1'b0;
    req_ready = '0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = grant;
        if (grant_any) begin
          accept  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        // The counter is sampled before it increments, so WIDTH-1 marks the last shift.
        if (bit_cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Going back through IDLE means no request can be granted in the handshake cycle.
        if (out_ready) begin
          out_hs  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath, arbitration pointer and statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opnd_q     <= '0;
      bcd_q      <= '0;
      bit_cnt_q  <= '0;
      ptr_q      <= '0;
      id_q       <= '0;
      conv_cnt_q <= '0;
    end else begin
      if (accept) begin
        opnd_q    <= req_opnd[grant_idx];
        bcd_q     <= '0;
        bit_cnt_q <= '0;
        id_q      <= grant_idx;
        ptr_q     <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
      end
      if (shift_en) begin
        // {bcd, operand} shifts left one place; the operand MSB enters BCD bit 0.
        bcd_q     <= {bcd_adj[BW-2:0], opnd_q[WIDTH-1]};
        opnd_q    <= {opnd_q[WIDTH-2:0], 1'b0};
        bit_cnt_q <= bit_cnt_q + CW'(1);
      end
      if (out_hs) begin
        conv_cnt_q <= conv_cnt_q + 8'd1;
      end
    end
  end

  // The BCD register keeps the last result after the handshake.
  // It is cleared only by the next accept.
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign out_bcd    = bcd_q;
  assign out_id     = id_q;
  assign conv_count = conv_cnt_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
module tb_bcd_conv_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [7:0]  d0 = 8'd0;
  logic [7:0]  d1 = 8'd0;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_bcd;
  logic [0:0]  out_id;
  logic        busy;
  logic [7:0]  conv_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [12:0] sb_q[$];    // expected {id, bcd}, in acceptance order
  int          grant_q[$]; // ids of granted requesters
  int          grant_t[$]; // cycle number of each grant
  logic [7:0]  cnt_model = 8'd0;

  assign req_data = {d1, d0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  bcd_conv_sched #(.WIDTH(8), .DIGITS(3), .NREQ(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_bcd(out_bcd), .out_id(out_id), .busy(busy), .conv_count(conv_count)
  );

  function automatic logic [11:0] to_bcd(input int v);
    to_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Scoreboard: push on request handshake, pop and compare on result handshake.
  always @(negedge clk) begin : monitor
    int          gid;
    logic [12:0] e;
    if (rst) begin
      sb_q.delete();
      cnt_model = 8'd0;
    end else begin
      checks++;
      if (conv_count !== cnt_model) begin
        errors++;
        $display("FAIL conv_count: got %0d expected %0d", conv_count, cnt_model);
      end
      if ((req_valid & req_ready) != 2'b00) begin
        checks++;
        if (req_ready != 2'b01 && req_ready != 2'b10) begin
          errors++;
          $display("FAIL grant_onehot: req_ready=%b", req_ready);
        end
        gid = req_ready[1] ? 1 : 0;
        sb_q.push_back({gid[0], to_bcd(gid == 1 ? int'(d1) : int'(d0))});
        grant_q.push_back(gid);
        grant_t.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: result id=%0d bcd=%h with empty scoreboard", out_id, out_bcd);
        end else begin
          e = sb_q.pop_front();
          if ({out_id, out_bcd} !== e) begin
            errors++;
            $display("FAIL sb_result: got id=%0d bcd=%h expected id=%0d bcd=%h",
                     out_id, out_bcd, e[12], e[11:0]);
          end
        end
        cnt_model = cnt_model + 8'd1;
      end
    end
  end

  task automatic wait_idle(input string tag);
    int c = 0;
    while (busy && c < 60) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy=%b expected 0", tag, busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks += 6;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (conv_count !== 8'd0) begin errors++; $display("FAIL rst_conv_count: got %0d expected 0", conv_count); end
    if (out_bcd !== 12'h000) begin errors++; $display("FAIL rst_out_bcd: got %h expected 000", out_bcd); end
    if (out_id !== 1'b0) begin errors++; $display("FAIL rst_out_id: got %0d expected 0", out_id); end
    if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready: got %b expected 00", req_ready); end
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_max();
    int n = 0;
    logic done = 1'b0;
    @(posedge clk);
    #2 d0 = 8'd255; req_valid = 2'b01; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL max_grant: got %b expected 01", req_ready); end
    @(posedge clk);
    #2 req_valid = 2'b00;
    while (!done && n < 40) begin
      @(posedge clk);
      n++;
      #1 done = out_valid;
    end
    checks += 4;
    if (n != 8 || !done) begin errors++; $display("FAIL max_latency: got %0d edges (valid=%b) expected 8", n, done); end
    if (out_bcd !== 12'h255) begin errors++; $display("FAIL max_bcd: got %h expected 255", out_bcd); end
    if (out_id !== 1'b0) begin errors++; $display("FAIL max_id: got %0d expected 0", out_id); end
    if (busy !== 1'b1) begin errors++; $display("FAIL max_busy_done: got %b expected 1", busy); end
    @(posedge clk);
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL max_valid_drop: got %b expected 0", out_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL max_busy_idle: got %b expected 0", busy); end
    if (out_bcd !== 12'h255) begin errors++; $display("FAIL max_bcd_hold: got %h expected 255", out_bcd); end
  endtask

  task automatic test_reset_mid_shift();
    @(posedge clk);
    #2 d0 = 8'd77; req_valid = 2'b01;
    @(posedge clk);
    #2 req_valid = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_pre_busy: got %b expected 1", busy); end
    #1 rst = 1'b1;
    #1;
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    if (conv_count !== 8'd0) begin errors++; $display("FAIL mid_conv_count: got %0d expected 0", conv_count); end
    if (out_bcd !== 12'h000) begin errors++; $display("FAIL mid_out_bcd: got %h expected 000", out_bcd); end
    if (out_id !== 1'b0) begin errors++; $display("FAIL mid_out_id: got %0d expected 0", out_id); end
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Both requesters valid all the time. Straight after reset the pointer is 0,
  // so the first grant must go to requester 0.
  task automatic test_alternate();
    int c = 0;
    int exp_id[4] = '{0, 1, 0, 1};
    grant_q.delete();
    grant_t.delete();
    @(posedge clk);
    #2 d0 = 8'd0; d1 = 8'd99; req_valid = 2'b11; out_ready = 1'b1;
    while (grant_q.size() < 4 && c < 100) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (grant_q.size() < 4) begin
      errors++;
      $display("FAIL alt_timeout: got %0d grants expected 4", grant_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (grant_q[k] != exp_id[k]) begin
          errors++;
          $display("FAIL alt_order[%0d]: got %0d expected %0d", k, grant_q[k], exp_id[k]);
        end
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (grant_t[k+1] - grant_t[k] != 10) begin
          errors++;
          $display("FAIL alt_spacing[%0d]: got %0d cycles expected 10", k, grant_t[k+1] - grant_t[k]);
        end
      end
    end
    @(posedge clk);
    #2 req_valid = 2'b00;
    wait_idle("alt");
  endtask

  task automatic test_stall();
    int c = 0;
    @(posedge clk);
    #2 d1 = 8'd200; d0 = 8'd42; req_valid = 2'b10; out_ready = 1'b0;
    while (req_ready[1] !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    @(posedge clk);
    #2 req_valid = 2'b01;
    c = 0;
    while (!out_valid && c < 40) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (!out_valid) begin errors++; $display("FAIL stall_timeout: out_valid=%b expected 1", out_valid); end
    repeat (20) begin
      @(negedge clk);
      checks += 4;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", out_valid); end
      if (out_bcd !== 12'h200) begin errors++; $display("FAIL stall_bcd: got %h expected 200", out_bcd); end
      if (out_id !== 1'b1) begin errors++; $display("FAIL stall_id: got %0d expected 1", out_id); end
      if (req_ready !== 2'b00) begin errors++; $display("FAIL stall_req_ready: got %b expected 00", req_ready); end
    end
    @(posedge clk);
    #2 out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL stall_hs_ready: got %b expected 00", req_ready); end
    @(negedge clk);
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_post_valid: got %b expected 0", out_valid); end
    if (req_ready !== 2'b01) begin errors++; $display("FAIL stall_post_grant: got %b expected 01", req_ready); end
    @(posedge clk);
    #2 req_valid = 2'b00;
    wait_idle("stall");
  endtask

  task automatic test_sweep();
    logic hit;
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0; out_ready = 1'b1; d1 = 8'd0; req_valid = 2'b10;
    for (int v = 0; v < 256; v++) begin
      hit = 1'b0;
      for (int c = 0; c < 40 && !hit; c++) begin
        @(negedge clk);
        hit = req_ready[1];
      end
      checks++;
      if (!hit) begin
        errors++;
        $display("FAIL sweep_grant_timeout: value %0d not accepted", v);
      end else if (v == 255 && conv_count !== 8'd255) begin
        errors++;
        $display("FAIL sweep_count_255: got %0d expected 255", conv_count);
      end
      @(posedge clk);
      #2 d1 = 8'(v + 1);
    end
    req_valid = 2'b00;
    wait_idle("sweep");
    checks += 2;
    if (conv_count !== 8'd0) begin errors++; $display("FAIL sweep_wrap: got %0d expected 0", conv_count); end
    if (sb_q.size() != 0) begin errors++; $display("FAIL sweep_leftover: %0d results still expected", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_max();
    test_reset_mid_shift();
    test_alternate();
    test_stall();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
